// File: rtl/paralelo_serial_tx.sv
// Serializes one byte per 8 clk cycles MSB-first: a COM preamble after reset, then data or IDLE filler.
// Bytes appear 1 cycle after their load edge; no backpressure. Optional BYTE_COUNT_EN adds the byte_count port.
module paralelo_serial_tx #(
  parameter int unsigned SYNC_COUNT = 4,
  parameter logic [7:0]  COM_BYTE   = 8'hBC,
  parameter logic [7:0]  IDLE_BYTE  = 8'h7C
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        data_out,
  output logic        byte_strobe,
`ifdef BYTE_COUNT_EN
  output logic [15:0] byte_count,
`endif
  output logic        sync_done
);

  typedef enum logic {SYNC_ST, DATA_ST} state_t;

  localparam logic [3:0] SYNC_CNT = 4'(SYNC_COUNT);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic [3:0]  com_cnt;
  logic        load_edge;
  logic        com_load;
  logic [7:0]  next_byte;

  assign load_edge = (bit_cnt == 3'd7);
  // Preamble slots still owed; with SYNC_COUNT==1 the first load edge already takes data.
  assign com_load  = (state == SYNC_ST) && (com_cnt < SYNC_CNT);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= SYNC_ST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (load_edge && (state == SYNC_ST)) begin
      if (!com_load || ((com_cnt + 4'd1) == SYNC_CNT)) begin
        state_nxt = DATA_ST;
      end
    end
  end

  always_comb begin
    byte_strobe = load_edge;
    sync_done   = (state == DATA_ST);
    data_out    = shift_reg[7];
  end

  always_comb begin
    next_byte = IDLE_BYTE;
    if (com_load) begin
      next_byte = COM_BYTE;
    end else if (valid_in) begin
      next_byte = data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt   <= 3'd0;
      shift_reg <= COM_BYTE;
      com_cnt   <= 4'd1;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (load_edge) begin
        shift_reg <= next_byte;
        if (com_load) begin
          com_cnt <= com_cnt + 4'd1;
        end
      end else begin
        shift_reg <= {shift_reg[6:0], 1'b0};
      end
    end
  end

`ifdef BYTE_COUNT_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      byte_count <= 16'd0;
    end else if (load_edge && !com_load && valid_in) begin
      byte_count <= byte_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench for paralelo_serial_tx: stimulus queues expected bytes, a monitor deserializes data_out.
module tb_paralelo_serial_tx;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        valid_in = 1'b0;
  logic        data_out;
  logic        byte_strobe;
  logic        sync_done;
`ifdef BYTE_COUNT_EN
  logic [15:0] byte_count;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  paralelo_serial_tx dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .byte_strobe(byte_strobe),
`ifdef BYTE_COUNT_EN
    .byte_count (byte_count),
`endif
    .sync_done  (sync_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks slot position from reset release and compares each completed byte.
  int bit_idx = 0;
  int cyc = 0;
  logic [7:0] acc = 8'h00;
  always @(negedge clk) begin
    if (!reset_L) begin
      bit_idx = 0;
      cyc = 0;
      acc = 8'h00;
    end else begin
      check("byte_strobe", 32'(byte_strobe), 32'(bit_idx == 7));
      check("sync_done", 32'(sync_done), 32'(cyc >= 24));
      acc = {acc[6:0], data_out};
      if (bit_idx == 7) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", acc, $time);
        end else begin
          check("serial_byte", 32'(acc), 32'(exp_q.pop_front()));
        end
        bit_idx = 0;
      end else begin
        bit_idx++;
      end
      if (cyc < 100000) cyc++;
    end
  end

  task automatic wait_strobe(input logic toggle);
    int n = 0;
    forever begin
      @(negedge clk);
      if (byte_strobe || n >= 16) break;
      n++;
      if (toggle) begin
        data_in  = (data_in == 8'h00) ? 8'hFF : 8'h00;
        valid_in = 1'b1;
      end
    end
    if (!byte_strobe) begin
      checks++;
      failures++;
      $display("FAIL strobe_timeout: got no strobe expected strobe within 16 cycles");
    end
  endtask

  task automatic send(input logic [7:0] d, input logic v, input logic toggle);
    wait_strobe(toggle);
    data_in  = d;
    valid_in = v;
    exp_q.push_back(v ? d : 8'h7C);
  endtask

  task automatic release_and_sync();
    @(posedge clk);
    #2 reset_L = 1'b1;
    repeat (4) exp_q.push_back(8'hBC);
    repeat (3) wait_strobe(1'b0);
  endtask

  task automatic check_reset_state();
    check("rst_data_out", 32'(data_out), 32'd1);
    check("rst_sync_done", 32'(sync_done), 32'd0);
    check("rst_byte_strobe", 32'(byte_strobe), 32'd0);
`ifdef BYTE_COUNT_EN
    check("rst_byte_count", 32'(byte_count), 32'd0);
`endif
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 check_reset_state();

    release_and_sync();
    send(8'hA5, 1'b1, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
`ifdef BYTE_COUNT_EN
    check("count_after_valid", 32'(byte_count), 32'd1);
`endif
    send(8'h3C, 1'b1, 1'b1);
`ifdef BYTE_COUNT_EN
    check("count_after_invalid", 32'(byte_count), 32'd1);
`endif
    send(8'h5A, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b0);
`ifdef BYTE_COUNT_EN
    check("count_three_valid", 32'(byte_count), 32'd3);
`endif

    // Abort a data byte four bits in; the partial byte is dropped.
    send(8'h81, 1'b1, 1'b0);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2 reset_L = 1'b0;
    exp_q.delete();
    #1 check_reset_state();
    repeat (2) @(posedge clk);

    release_and_sync();
    send(8'hC3, 1'b1, 1'b0);
    send(8'h18, 1'b1, 1'b0);
    send(8'hFF, 1'b0, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
